// File: rtl/mem_copy_engine.sv
// Block-copy initiator driving both ports of a dual-port memory: reads via port A, writes via port B.
// Optional XOR checksum of written words is built when MEM_COPY_CHECKSUM_EN is defined.
module mem_copy_engine #(
  parameter int DATA = 8,
  parameter int ADDR = 4
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            start,
  input  logic [ADDR-1:0] src,
  input  logic [ADDR-1:0] dst,
  input  logic [ADDR:0]   len,
  output logic            busy,
  output logic            done,
  output logic            m_a_wr,
  output logic [ADDR-1:0] m_a_addr,
  output logic [DATA-1:0] m_a_din,
  input  logic [DATA-1:0] m_a_dout,
  output logic            m_b_wr,
  output logic [ADDR-1:0] m_b_addr,
  output logic [DATA-1:0] m_b_din,
  output logic [DATA-1:0] csum
);

  typedef enum logic [1:0] {IDLE, RUN, DRAIN, FIN} state_t;

  localparam logic [ADDR:0] MAX_LEN = {1'b1, {ADDR{1'b0}}};

  state_t        state;
  logic [ADDR:0] len_q;
  logic [ADDR:0] cnt;
  logic [ADDR:0] len_clamped;

  assign len_clamped = (len > MAX_LEN) ? MAX_LEN : len;

  assign m_a_wr  = 1'b0;
  assign m_a_din = '0;
  // Write data is the previous cycle's read, so the write lags the read by one cycle.
  assign m_b_din = m_a_dout;

  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= IDLE;
      busy     <= 1'b0;
      done     <= 1'b0;
      m_b_wr   <= 1'b0;
      m_a_addr <= '0;
      m_b_addr <= '0;
      len_q    <= '0;
      cnt      <= '0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: begin
          if (start) begin
            len_q    <= len_clamped;
            m_a_addr <= src;
            m_b_addr <= dst;
            m_b_wr   <= 1'b0;
            cnt      <= {{ADDR{1'b0}}, 1'b1};
            if (len_clamped == '0) begin
              state <= FIN;
              done  <= 1'b1;
            end else begin
              state <= RUN;
              busy  <= 1'b1;
            end
          end
        end
        RUN: begin
          // cnt counts reads presented so far, including the current one.
          m_b_wr <= 1'b1;
          if (m_b_wr) m_b_addr <= m_b_addr + 1'b1;
          if (cnt == len_q) begin
            state <= DRAIN;
          end else begin
            cnt      <= cnt + 1'b1;
            m_a_addr <= m_a_addr + 1'b1;
          end
        end
        DRAIN: begin
          m_b_wr <= 1'b0;
          busy   <= 1'b0;
          done   <= 1'b1;
          state  <= FIN;
        end
        FIN: state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

`ifdef MEM_COPY_CHECKSUM_EN
  always_ff @(posedge clk) begin
    if (rst)                        csum <= '0;
    else if (state == IDLE && start) csum <= '0;
    else if (m_b_wr)                csum <= csum ^ m_a_dout;
  end
`else
  assign csum = '0;
`endif

endmodule
